// File: rtl/dense_layer_sequencer.sv
// Sequences one dense-layer pass over a fixed-latency MAC datapath: issues weight rows, retires
// results with bias, saturation and optional ReLU, and buffers them in a credit-protected FIFO.
module dense_layer_sequencer #(
  parameter int unsigned NUM_NEURONS          = 16,
  parameter int unsigned FIXED_POINT_WIDTH    = 16,
  parameter int unsigned FIXED_POINT_POSITION = 10,
  parameter int unsigned PIPELINE_LATENCY     = 8,
  localparam int unsigned ADDR_WIDTH = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         start_in,
  input  logic                         relu_enable_in,
  output logic                         busy_out,
  output logic                         done_out,
  output logic [ADDR_WIDTH-1:0]        weight_addr_out,
  output logic                         mac_issue_out,
  input  logic [FIXED_POINT_WIDTH-1:0] mac_result_in,
  output logic [ADDR_WIDTH-1:0]        bias_addr_out,
  input  logic [FIXED_POINT_WIDTH-1:0] bias_in,
  output logic                         result_valid_out,
  input  logic                         result_ready_in,
  output logic [ADDR_WIDTH-1:0]        result_addr_out,
  output logic [FIXED_POINT_WIDTH-1:0] result_data_out
);

  localparam int unsigned W          = FIXED_POINT_WIDTH;
  localparam int unsigned FIFO_DEPTH = PIPELINE_LATENCY + 1;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned POP_W      = $clog2(NUM_NEURONS + 1);
  localparam int unsigned ENTRY_W    = ADDR_WIDTH + W;

  // Bias and result share one Q format, so the binary point never moves.
  logic unused_q_format;
  assign unused_q_format = (FIXED_POINT_POSITION < FIXED_POINT_WIDTH);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [ADDR_WIDTH-1:0]   baddr_q, baddr_d;
  logic                    relu_q, relu_d;
  logic [CNT_W-1:0]        credits_q, credits_d;
  logic [PIPELINE_LATENCY-1:0] tag_q, tag_d;
  logic [POP_W-1:0]        pops_q, pops_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [ENTRY_W-1:0]      mem_q [FIFO_DEPTH];

  logic            start_acc;
  logic            issue;
  logic            retire;
  logic            pop;
  logic            fifo_valid;
  logic            last_issue;
  logic            last_retire;
  logic            last_pop;
  logic [W:0]      sum;
  logic [W-1:0]    sat;
  logic [W-1:0]    act;
  logic [ENTRY_W-1:0] head;

  assign start_acc   = (state_q == StIdle) && start_in;
  assign retire      = tag_q[PIPELINE_LATENCY-1];
  assign fifo_valid  = (count_q != '0);
  assign pop         = fifo_valid && result_ready_in;
  assign last_issue  = (waddr_q == ADDR_WIDTH'(NUM_NEURONS - 1));
  assign last_retire = (baddr_q == ADDR_WIDTH'(NUM_NEURONS - 1));
  assign last_pop    = (pops_q == POP_W'(NUM_NEURONS - 1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_in) state_d = StIssue;
      StIssue: if (issue && last_issue) state_d = StDrain;
      StDrain: if (pop && last_pop) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A pop in the same cycle returns a credit, so an empty counter plus a pop still issues;
  // this keeps a FIFO of PIPELINE_LATENCY+1 stall-free when the consumer is always ready.
  always_comb begin
    busy_out = (state_q != StIdle);
    done_out = (state_q == StDone);
    issue    = (state_q == StIssue) && ((credits_q != '0) || pop);
  end

  assign mac_issue_out   = issue;
  assign weight_addr_out = waddr_q;
  assign bias_addr_out   = baddr_q;

  // ---------------------------------------------------------------------------
  // Issue / retire bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    waddr_d = waddr_q;
    if (start_acc) begin
      waddr_d = '0;
    end else if (issue) begin
      waddr_d = last_issue ? '0 : waddr_q + 1'b1;
    end

    baddr_d = baddr_q;
    if (start_acc) begin
      baddr_d = '0;
    end else if (retire) begin
      baddr_d = last_retire ? '0 : baddr_q + 1'b1;
    end

    pops_d = pops_q;
    if (start_acc) begin
      pops_d = '0;
    end else if (pop) begin
      pops_d = pops_q + 1'b1;
    end

    relu_d    = start_acc ? relu_enable_in : relu_q;
    credits_d = credits_q + CNT_W'(pop) - CNT_W'(issue);

    tag_d    = tag_q;
    tag_d[0] = issue;
    for (int unsigned i = 1; i < PIPELINE_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      waddr_q   <= '0;
      baddr_q   <= '0;
      pops_q    <= '0;
      relu_q    <= 1'b0;
      credits_q <= CNT_W'(FIFO_DEPTH);
      tag_q     <= '0;
    end else begin
      waddr_q   <= waddr_d;
      baddr_q   <= baddr_d;
      pops_q    <= pops_d;
      relu_q    <= relu_d;
      credits_q <= credits_d;
      tag_q     <= tag_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Bias add, saturation, activation
  // ---------------------------------------------------------------------------
  always_comb begin
    sum = {mac_result_in[W-1], mac_result_in} + {bias_in[W-1], bias_in};
    if (sum[W] != sum[W-1]) begin
      sat = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sat = sum[W-1:0];
    end
    act = (relu_q && sat[W-1]) ? '0 : sat;
  end

  // ---------------------------------------------------------------------------
  // Result FIFO (no bypass: a push shows up at the head one cycle later)
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (retire) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(retire) - CNT_W'(pop);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (retire) begin
      mem_q[wr_ptr_q] <= {baddr_q, act};
    end
  end

  assign head             = mem_q[rd_ptr_q];
  assign result_valid_out = fifo_valid;
  assign result_addr_out  = fifo_valid ? head[ENTRY_W-1:W] : '0;
  assign result_data_out  = fifo_valid ? head[W-1:0] : '0;

endmodule
